// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and constants for the register file.
package regfile_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 1 << RF_ADDR_W;
    localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: combinational read mux with reset, enable, zero-register and bypass priority.
// Ports:
//   rst    in   reset, forces 0
//   re     in   read enable, 0 forces 0
//   raddr  in   read address, 0 forces 0
//   entry  in   stored value of entry[raddr]
//   we     in   write enable of the write port
//   waddr  in   write address
//   wdata  in   write data (forwarded when BYPASS_EN and addresses match)
//   rdata  out  read data
module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] entry,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic w_fwd;
    always_comb begin
        w_fwd = BYPASS_EN && we && (waddr == raddr);
        rdata = (rst || !re || raddr == '0) ? '0 : w_fwd ? wdata : entry;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32-entry MIPS register file, two read ports with same-cycle bypass, one write port, debug read.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   we, waddr, wdata    write port from write-back
//   re1, raddr1, rdata1 read port 1
//   re2, raddr2, rdata2 read port 2
//   dbg_addr, dbg_data  debug read, no enable, no bypass
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Entry 0 is never written, so it holds the reset value of 0 forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (we && waddr != '0) begin
            r_mem[waddr] <= wdata;
        end
    end

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rd1 (
        .rst(rst), .re(re1), .raddr(raddr1), .entry(r_mem[raddr1]),
        .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata1)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rd2 (
        .rst(rst), .re(re2), .raddr(raddr2), .entry(r_mem[raddr2]),
        .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata2)
    );

    // Debug view shows only committed state: always enabled, never forwarded.
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(1'b0)) u_rd_dbg (
        .rst(rst), .re(1'b1), .raddr(dbg_addr), .entry(r_mem[dbg_addr]),
        .we(1'b0), .waddr('0), .wdata('0), .rdata(dbg_data)
    );
endmodule
